// File: rtl/alu_pkg.sv
// ALU operation codes and divider FSM state shared by the EX-stage datapath.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_DIVU = 4'b0100;
  localparam logic [3:0] ALU_BNE  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divu_state_e;

endpackage

// File: rtl/divu_step.sv
// One combinational restoring shift-subtract step of the unsigned divider.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // The partial remainder stays below the divisor, so WIDTH+1 bits hold the sign of the trial.
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, divisor};
  assign rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/divu_seq.sv
// Multi-cycle unsigned restoring divider for DIVU; WIDTH+1 cycles start-to-done, busy stalls EX.
// DIVU_DBZ_FAST_EN: a zero divisor completes in one cycle and raises div_by_zero.
module divu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       SignalIn,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  divu_state_e      state_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             accept;

  assign accept = start && (SignalIn == ALU_DIVU);

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvsr_q),
    .rem_nxt (rem_d),
    .quo_nxt (quo_d)
  );

`ifdef DIVU_DBZ_FAST_EN
  logic dbz_q;
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIVU_DBZ_FAST_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= quo_d;
              remainder_q <= rem_d;
`ifdef DIVU_DBZ_FAST_EN
              dbz_q       <= 1'b0;
`endif
            end
          end
          default: begin
            if (accept) begin
              dvsr_q <= divisor;
              rem_q  <= '0;
              quo_q  <= dividend;
              cnt_q  <= '0;
`ifdef DIVU_DBZ_FAST_EN
              if (divisor == '0) begin
                state_q     <= DONE;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                quotient_q  <= '1;
                remainder_q <= dividend;
                dbz_q       <= 1'b1;
              end else begin
                state_q <= RUN;
                busy_q  <= 1'b1;
              end
`else
              state_q <= RUN;
              busy_q  <= 1'b1;
`endif
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
